// File: rtl/mac_mdc_package.sv
// Shared types and constants for the MAC/MDC job dispatcher.
//   job_t       : one queued job (three buffer addresses and a length)
//   REG_*       : byte offsets of the accelerator registers the dispatcher touches
//   state_t     : dispatcher FSM states
//   cfg_offset  : register offset written at a given configuration step
//   cfg_data    : value written at a given configuration step
package mac_mdc_package;

  typedef struct packed {
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] addr_d;
    logic [15:0] len;
  } job_t;

  localparam logic [31:0] REG_TRIGGER  = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS   = 32'h0000_0004;
  localparam logic [31:0] REG_SOFT_CLR = 32'h0000_0014;
  localparam logic [31:0] REG_ADDR_A   = 32'h0000_0040;
  localparam logic [31:0] REG_ADDR_B   = 32'h0000_0044;
  localparam logic [31:0] REG_ADDR_D   = 32'h0000_0048;
  localparam logic [31:0] REG_LEN      = 32'h0000_004C;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    ACQ_WAIT,
    CFG,
    TRIG,
    RUN,
    CLR
  } state_t;

  function automatic logic [31:0] cfg_offset(input logic [1:0] idx);
    logic [31:0] off;
    case (idx)
      2'd0:    off = REG_ADDR_A;
      2'd1:    off = REG_ADDR_B;
      2'd2:    off = REG_ADDR_D;
      default: off = REG_LEN;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] cfg_data(input job_t job, input logic [1:0] idx);
    logic [31:0] val;
    case (idx)
      2'd0:    val = job.addr_a;
      2'd1:    val = job.addr_b;
      2'd2:    val = job.addr_d;
      default: val = {16'h0000, job.len};
    endcase
    return val;
  endfunction

endpackage

// File: rtl/mac_mdc_job_fifo.sv
// Job queue for the dispatcher. The head entry stays visible on head until
// it is popped, so the dispatcher can read it across a whole job.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the queue)
//   push, push_data : enqueue request and job; ignored while full
//   pop           : dequeue the head; ignored while empty
//   full, empty   : occupancy flags
//   head          : oldest entry (undefined while empty)
module mac_mdc_job_fifo
  import mac_mdc_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  job_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output job_t head
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mac_mdc_job_dispatcher.sv
// Dispatches queued jobs to a MAC/MDC accelerator through its register port.
// Per job: poll the status register until the accelerator is free, write the
// four configuration registers, trigger, then wait for the end-of-job event.
// A watchdog aborts a job that runs too long by issuing a soft clear.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   job_valid_i/ready_o  : job queue write handshake, job_i carries the job
//   periph_*             : register access port (req/gnt, address, wen 0=write,
//                          byte enables, write data, id, read data + valid)
//   evt_i                : end-of-job pulse from the accelerator
//   busy_o               : a job is in progress
//   done_o / err_o       : one-cycle pulse on completion / watchdog abort
//   jobs_done_o          : count of completed jobs (wraps)
module mac_mdc_job_dispatcher
  import mac_mdc_package::*;
#(
  parameter int          ID         = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 65535
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  job_t          job_i,
  output logic          periph_req_o,
  input  logic          periph_gnt_i,
  output logic [31:0]   periph_add_o,
  output logic          periph_wen_o,
  output logic [3:0]    periph_be_o,
  output logic [31:0]   periph_data_o,
  output logic [ID-1:0] periph_id_o,
  input  logic [31:0]   periph_r_data_i,
  input  logic          periph_r_valid_i,
  input  logic          evt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   jobs_done_o
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  cfg_idx_q;
  logic [31:0] wdog_q;
  logic        done_q, err_q;
  logic [15:0] jobs_done_q;

  logic        fifo_full, fifo_empty;
  job_t        head_job;
  logic        job_done, job_abort;

  // Only the busy flag of the status word matters; the rest is don't-care.
  logic        unused_rdata;
  assign unused_rdata = ^periph_r_data_i[30:0];

  mac_mdc_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (job_valid_i),
    .push_data (job_i),
    .pop       (job_done || job_abort),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_job)
  );

  // Bus outputs depend only on registered state and the registered queue
  // head, so no input reaches an output combinationally.
  // NOTE: every signal driven here gets a default first; a branch that
  // forgets one would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b1;
    periph_be_o   = 4'h0;
    periph_data_o = '0;
    job_done      = 1'b0;
    job_abort     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ACQ;
      end

      ACQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + REG_STATUS;
        periph_be_o  = 4'hF;
        if (periph_gnt_i) state_d = ACQ_WAIT;
      end

      ACQ_WAIT: begin
        // Status bit 31 set means the accelerator is still owned: poll again.
        if (periph_r_valid_i) begin
          state_d = periph_r_data_i[31] ? ACQ : CFG;
        end
      end

      CFG: begin
        periph_req_o  = 1'b1;
        periph_wen_o  = 1'b0;
        periph_be_o   = 4'hF;
        periph_add_o  = BASE_ADDR + cfg_offset(cfg_idx_q);
        periph_data_o = cfg_data(head_job, cfg_idx_q);
        if (periph_gnt_i && (cfg_idx_q == 2'd3)) state_d = TRIG;
      end

      TRIG: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b0;
        periph_be_o  = 4'hF;
        periph_add_o = BASE_ADDR + REG_TRIGGER;
        if (periph_gnt_i) state_d = RUN;
      end

      RUN: begin
        // The event wins over a watchdog expiry in the same cycle.
        if (evt_i) begin
          job_done = 1'b1;
          state_d  = IDLE;
        end else if (wdog_q == TIMEOUT_W) begin
          state_d = CLR;
        end
      end

      CLR: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b0;
        periph_be_o  = 4'hF;
        periph_add_o = BASE_ADDR + REG_SOFT_CLR;
        if (periph_gnt_i) begin
          job_abort = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cfg_idx_q   <= 2'd0;
      wdog_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= job_done;
      err_q   <= job_abort;

      // Index wraps to 0 on the last configuration grant, ready for the next job.
      if ((state_q == CFG) && periph_gnt_i) cfg_idx_q <= cfg_idx_q + 2'd1;

      // Watchdog reads 0 in the first RUN cycle and counts up while in RUN.
      if (state_q == RUN) wdog_q <= wdog_q + 32'd1;
      else                wdog_q <= '0;

      if (job_done) jobs_done_q <= jobs_done_q + 16'd1;
    end
  end

  assign job_ready_o = !fifo_full;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign jobs_done_o = jobs_done_q;
  assign periph_id_o = '0;

endmodule

// File: tb/tb_mac_mdc_job_dispatcher.sv
// Self-checking bench for mac_mdc_job_dispatcher. A bus/accelerator model
// answers register accesses with configurable grant delays, returns queued
// status words and fires end-of-job events a chosen number of cycles after
// the trigger write. Expected access streams and completion counts are
// derived per job from the dispatcher's rules.
module tb_mac_mdc_job_dispatcher;
  import mac_mdc_package::*;

  localparam logic [31:0] BASE  = 32'h1A10_0000;
  localparam int          TMO   = 100;
  localparam int          DEPTH = 4;
  localparam int          IDW   = 10;

  logic           clk_i;
  logic           rst_ni;
  logic           job_valid_i;
  logic           job_ready_o;
  job_t           job_i;
  logic           periph_req_o;
  logic           periph_gnt_i;
  logic [31:0]    periph_add_o;
  logic           periph_wen_o;
  logic [3:0]     periph_be_o;
  logic [31:0]    periph_data_o;
  logic [IDW-1:0] periph_id_o;
  logic [31:0]    periph_r_data_i;
  logic           periph_r_valid_i;
  logic           evt_i;
  logic           busy_o;
  logic           done_o;
  logic           err_o;
  logic [15:0]    jobs_done_o;

  mac_mdc_job_dispatcher #(
    .ID         (IDW),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .job_valid_i      (job_valid_i),
    .job_ready_o      (job_ready_o),
    .job_i            (job_i),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_valid_i (periph_r_valid_i),
    .evt_i            (evt_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .jobs_done_o      (jobs_done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] resp_q[$];
  int          evt_q[$];

  int checks = 0;
  int errors = 0;

  int cycle = 0, n_acc = 0, n_rd = 0, trig_cnt = 0;
  int done_seen = 0, err_seen = 0, exp_done = 0, exp_err = 0, outstanding = 0;
  int gnt_lo = 0, gnt_hi = 0, stray_req = 0, stray_seen = 0;

  bit          holding = 0, rd_pending = 0;
  int          wait_left = 0, evt_cnt = 0, req_start = 0, trig_cycle = 0;
  logic [31:0] h_add;
  logic [36:0] h_ctl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, job_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_req"}, periph_req_o, 0);
    check({tag, "_wen"}, periph_wen_o, 1);
    check({tag, "_add"}, periph_add_o, 0);
    check({tag, "_be"}, periph_be_o, 0);
    check({tag, "_data"}, periph_data_o, 0);
    check({tag, "_id"}, periph_id_o, 0);
    check({tag, "_jobs"}, jobs_done_o, 0);
  endtask

  // Bus and accelerator model, evaluated once per falling edge.
  task automatic slave_step();
    acc_t        e;
    logic [36:0] ctl;
    cycle++;
    evt_i            = 1'b0;
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b0;
    periph_r_data_i  = $urandom;
    if (!rst_ni) begin
      holding    = 0;
      rd_pending = 0;
      evt_cnt    = 0;
      return;
    end
    if (stray_req != stray_seen) begin
      stray_seen = stray_req;
      evt_i      = 1'b1;
    end
    if (evt_cnt > 0) begin
      evt_cnt--;
      if (evt_cnt == 0) evt_i = 1'b1;
    end
    if (rd_pending) begin
      rd_pending       = 0;
      periph_r_valid_i = 1'b1;
      periph_r_data_i  = (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
    end
    if (done_o) begin done_seen++; outstanding--; end
    if (err_o)  begin err_seen++;  outstanding--; end

    if (periph_req_o) begin
      ctl = {periph_wen_o, periph_be_o, periph_data_o};
      if (!holding) begin
        holding   = 1;
        h_add     = periph_add_o;
        h_ctl     = ctl;
        wait_left = $urandom_range(gnt_hi, gnt_lo);
        req_start = cycle;
      end else begin
        check("hold_add", periph_add_o, h_add);
        check("hold_ctl", ctl, h_ctl);
      end
      if (wait_left == 0) begin
        periph_gnt_i = 1'b1;
        holding      = 0;
        n_acc++;
        check("acc_id", periph_id_o, 0);
        if (exp_q.size() == 0) begin
          check("acc_extra", periph_add_o, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("acc_add", periph_add_o, e.add);
          check("acc_ctl", ctl, {e.wen, 4'hF, e.data});
        end
        if (periph_wen_o) begin
          rd_pending = 1;
          n_rd++;
        end else if (periph_add_o == BASE) begin
          trig_cnt++;
          trig_cycle = cycle;
          evt_cnt    = (evt_q.size() > 0) ? evt_q.pop_front() : 0;
        end else if (periph_add_o == BASE + 32'h14) begin
          // Soft clear request must appear right after the RUN window closes.
          check("timeout_len", req_start - trig_cycle, TMO + 2);
        end
      end else begin
        wait_left--;
      end
    end
  endtask

  // Push one job. n_busy status reads report busy before the free one; the
  // end-of-job event fires k cycles after the trigger grant (0 = never).
  // The event lands inside the RUN window for 1 <= k <= TMO+1.
  task automatic push_job(input int n_busy, input int k, output logic [15:0] jd_at_accept);
    job_t j;
    int   guard;
    j.addr_a = $urandom;
    j.addr_b = $urandom;
    j.addr_d = $urandom;
    j.len    = 16'($urandom);
    @(negedge clk_i);
    job_valid_i = 1'b1;
    job_i       = j;
    guard       = 0;
    while (!job_ready_o && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    jd_at_accept = jobs_done_o;
    if (guard >= 2000) begin
      check("push_wait", 0, 1);
    end else begin
      for (int i = 0; i < n_busy; i++) begin
        resp_q.push_back($urandom | 32'h8000_0000);
        exp_q.push_back('{BASE + 32'h04, 1'b1, 32'h0});
      end
      resp_q.push_back($urandom & 32'h7FFF_FFFF);
      exp_q.push_back('{BASE + 32'h04, 1'b1, 32'h0});
      exp_q.push_back('{BASE + 32'h40, 1'b0, j.addr_a});
      exp_q.push_back('{BASE + 32'h44, 1'b0, j.addr_b});
      exp_q.push_back('{BASE + 32'h48, 1'b0, j.addr_d});
      exp_q.push_back('{BASE + 32'h4C, 1'b0, {16'h0, j.len}});
      exp_q.push_back('{BASE, 1'b0, 32'h0});
      evt_q.push_back(k);
      if (k >= 1 && k <= TMO + 1) begin
        exp_done++;
      end else begin
        exp_q.push_back('{BASE + 32'h14, 1'b0, 32'h0});
        exp_err++;
      end
      outstanding++;
    end
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((outstanding > 0 || exp_q.size() > 0 || busy_o) && guard < 5000) begin
      @(negedge clk_i);
      guard++;
    end
    check({tag, "_drain"}, guard < 5000, 1);
    repeat (3) @(negedge clk_i);
    check({tag, "_done_cnt"}, done_seen, exp_done);
    check({tag, "_err_cnt"}, err_seen, exp_err);
    check({tag, "_jobs_done"}, jobs_done_o, 16'(exp_done));
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] jd, jd_base;
    int          a0, r0, g;

    rst_ni           = 1'b1;
    job_valid_i      = 1'b0;
    job_i            = '0;
    periph_gnt_i     = 1'b0;
    periph_r_data_i  = '0;
    periph_r_valid_i = 1'b0;
    evt_i            = 1'b0;
    #2 rst_ni = 1'b0;

    fork
      forever begin
        @(negedge clk_i);
        slave_step();
      end
    join_none

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Events while idle are ignored.
    stray_req++;
    repeat (4) @(negedge clk_i);
    check("stray_busy", busy_o, 0);
    check("stray_done", done_seen, 0);

    // Single job, immediate grants, event 20 cycles after trigger.
    a0 = n_acc;
    push_job(0, 20, jd);
    drain("single");
    check("single_accesses", n_acc - a0, 6);

    // Two busy status reads before the accelerator is free.
    a0 = n_acc; r0 = n_rd;
    push_job(2, 15, jd);
    drain("retry");
    check("retry_reads", n_rd - r0, 3);
    check("retry_accesses", n_acc - a0, 8);

    // Every grant delayed by three cycles; hold checks run in the bus model.
    gnt_lo = 3; gnt_hi = 3;
    a0 = n_acc;
    push_job(0, 25, jd);
    drain("slow_gnt");
    check("slow_accesses", n_acc - a0, 6);

    // Fill the queue while the first job runs.
    gnt_lo = 0; gnt_hi = 2;
    jd_base = 16'(exp_done);
    g = trig_cnt;
    push_job(0, 60, jd);
    a0 = 0;
    while (trig_cnt == g && a0 < 500) begin
      @(negedge clk_i);
      a0++;
    end
    check("fill_trig_seen", a0 < 500, 1);
    push_job(0, 10, jd);
    push_job(1, 10, jd);
    push_job(0, 10, jd);
    check("full_ready", job_ready_o, 0);
    push_job(0, 10, jd);
    check("push5_after_pop", jd, jd_base + 16'd1);
    drain("fill");

    // Watchdog: abort, then the next job completes normally.
    gnt_lo = 0; gnt_hi = 0;
    push_job(0, 0, jd);
    push_job(0, 12, jd);
    drain("timeout");

    // Event in the last watchdog cycle completes; one cycle later it is ignored.
    push_job(0, TMO + 1, jd);
    push_job(1, TMO + 2, jd);
    drain("tmo_edge");

    // Randomized mix of retries, grant delays, completions and aborts.
    gnt_lo = 0; gnt_hi = 3;
    for (int n = 0; n < 12; n++) begin
      int r, k;
      r = $urandom_range(9, 0);
      if (r == 0)      k = 0;
      else if (r == 1) k = TMO + 1;
      else             k = $urandom_range(60, 1);
      push_job($urandom_range(2, 0), k, jd);
    end
    drain("random");

    // Asynchronous reset during the third configuration write.
    gnt_lo = 3; gnt_hi = 3;
    push_job(0, 30, jd);
    g = 0;
    while (!(periph_req_o && periph_add_o == BASE + 32'h48) && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    check("cfg2_reached", g < 500, 1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    resp_q.delete();
    evt_q.delete();
    outstanding = 0;
    exp_done = 0; exp_err = 0; done_seen = 0; err_seen = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_ready", job_ready_o, 1);
    repeat (10) @(negedge clk_i);
    check("post_rst_idle", busy_o, 0);
    check("post_rst_req", periph_req_o, 0);

    // Dispatcher still works after the reset.
    gnt_lo = 0; gnt_hi = 1;
    push_job(0, 8, jd);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_mdc_job_dispatcher.md
MAC_MDC_JOB_DISPATCHER -- requirements
Module: mac_mdc_job_dispatcher

Interface
REQ-001 SHALL have parameter ID, default 10: width of periph_id_o.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base of the accelerator register file.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2): job queue entries.
REQ-004 SHALL have parameter TIMEOUT, default 65535: maximum cycles in RUN before abort.
REQ-005 SHALL have ports, in order:
 - clk_i  in  1  clock.
 - rst_ni  in  1  asynchronous active-low reset.
 - job_valid_i  in  1  job offered.
 - job_ready_o  out  1  queue not full.
 - job_i  in  job_t  job fields: addr_a, addr_b, addr_d (32 b each), len (16 b).
 - periph_req_o  out  1  register access request.
 - periph_gnt_i  in  1  access granted.
 - periph_add_o  out  32  byte address.
 - periph_wen_o  out  1  0 = write, 1 = read.
 - periph_be_o  out  4  byte enables.
 - periph_data_o  out  32  write data.
 - periph_id_o  out  ID  transaction id.
 - periph_r_data_i  in  32  read data.
 - periph_r_valid_i  in  1  read data valid.
 - evt_i  in  1  accelerator end-of-job event (single-cycle pulse).
 - busy_o  out  1  FSM not in IDLE.
 - done_o  out  1  one-cycle pulse on job completion.
 - err_o  out  1  one-cycle pulse on timeout abort.
 - jobs_done_o  out  16  completed-job counter.

Function
REQ-006 SHALL accept a job when job_valid_i and job_ready_o are both high at a rising clock edge; job_ready_o SHALL be low only when the queue holds FIFO_DEPTH entries.
REQ-007 SHALL implement FSM states IDLE, ACQ, ACQ_WAIT, CFG, TRIG, RUN, CLR.
REQ-008 IDLE->ACQ when the queue is non-empty; the head entry SHALL NOT be popped until the job reaches DONE or abort.
REQ-009 ACQ: read at BASE_ADDR+0x04; SHALL hold req/add/wen/be/data/id stable until periph_gnt_i; ACQ->ACQ_WAIT on grant.
REQ-010 ACQ_WAIT: on periph_r_valid_i, go to CFG if r_data[31]==0, else return to ACQ (retry; no backoff).
REQ-011 CFG: four writes in order, each held until granted:
 - 0x40 addr_a
 - 0x44 addr_b
 - 0x48 addr_d
 - 0x4C {16'h0, len}
 A 2-bit index SHALL advance per grant; be=4'hF; no r_valid wait for writes.
REQ-012 TRIG: write 0 to BASE_ADDR+0x00; on grant go to RUN.
REQ-013 RUN: a 32-bit watchdog SHALL start at 0 and increment each cycle; on evt_i pop the head, pulse done_o, increment jobs_done_o (wraps 0xFFFF->0), and go to IDLE.
REQ-014 RUN: when the watchdog reaches TIMEOUT without evt_i, go to CLR; evt_i in that same cycle SHALL take priority (completion).
REQ-015 CLR: write 0 to BASE_ADDR+0x14 (soft clear); on grant pulse err_o, pop the head without counting, and go to IDLE.
REQ-016 evt_i outside RUN SHALL be ignored.
REQ-017 periph_id_o SHALL be constant 0; periph_req_o SHALL be low in IDLE and RUN.
REQ-018 A push and a pop in the same cycle SHALL both take effect; a push when full SHALL be dropped (job_ready_o low).
REQ-019 Combinational input-to-output paths SHALL NOT exist except job_ready_o from queue state.

Reset
REQ-020 Assertion of rst_ni at any time, including mid-transaction, SHALL force IDLE and empty the queue; busy_o, done_o, err_o, periph_req_o, jobs_done_o and the watchdog SHALL be 0, periph_wen_o 1, other outputs 0, job_ready_o 1.

Structure
REQ-021 job_t, the register offsets (0x00, 0x04, 0x14, 0x40-0x4C) and the FSM state enum SHALL live in mac_mdc_package.
REQ-022 The queue SHALL be a sub-module mac_mdc_job_fifo (push/pop/full/empty, head data output).

Verification
REQ-023 Single job, gnt tied high, ACQ read 0x0, evt_i 20 cycles after TRIG: exactly 6 accesses (0x04 rd, 0x40-0x4C wr, 0x00 wr); done_o is one pulse; jobs_done_o=1.
REQ-024 ACQ reads return 0xFFFFFFFF twice, then 0x1: three reads at 0x04 precede CFG.
REQ-025 gnt delayed 3 cycles per access: address and data are held stable for the whole wait; the write order is unchanged.
REQ-026 Push 5 jobs with FIFO_DEPTH=4 during RUN: job_ready_o is low after the 4th; the 5th is not accepted until the first pop.
REQ-027 TIMEOUT=100, no evt_i: a write to 0x14 issues after 100 RUN cycles; err_o pulses; jobs_done_o is unchanged; the next job starts.
REQ-028 rst_ni low during CFG index 2: outputs take their reset values asynchronously; after release, busy_o=0 and the queue is empty.
